axis_replay_buffer: RTL and testbench
=====================================

# axis_replay_buffer

Sample buffer that sits directly downstream of the GPIO-to-AXIS writer: it accepts the 16-bit coefficient words assembled from PS GPIO writes on an AXI-stream slave port, stores them in block RAM, and on command replays the stored sequence at one sample per cycle to the DAC/datapath stream. One instance serves the "a" channel and one the "c" channel, so the Ising-machine coefficients are loaded once and replayed every round trip.

## Interface
- `num_bits`, 16: sample width; matches the writer's data width.
- `depth`, 1024: sample capacity; power of two, ≥ 4.
- `addr_bits`, $clog2(depth): RAM address width; derived, never overridden.

- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `s_data`  in  num_bits: load sample from the writer.
- `s_valid`  in  1: load sample valid.
- `s_rdy`  out  1: buffer can accept a load sample.
- `m_data`  out  num_bits: replay sample.
- `m_valid`  out  1: replay sample valid.
- `m_rdy`  in  1: downstream accepts the replay sample.
- `start`  in  1: one-cycle pulse that begins replay.
- `stop`  in  1: one-cycle pulse that aborts replay.
- `clear`  in  1: one-cycle pulse that empties the buffer.
- `loop_en`  in  1: level; wrap to sample 0 after the last sample instead of finishing.
- `count`  out  addr_bits+1: number of stored samples.
- `busy`  out  1: high while in PLAY.
- `done`  out  1: one-cycle pulse when a non-looping pass completes.

## Operation
- Two states: LOAD (reset state) and PLAY.
- LOAD:
  - `s_rdy` = (count != depth).
  - On `s_valid && s_rdy`, write to mem[count] and increment `count`.
  - `clear` sets `count` to 0. If a write handshake occurs in the same cycle, `clear` wins and the sample is discarded.
  - `start` with `count != 0` moves to PLAY with read pointer 0. The pass length is `count` as it stands after any same-cycle write, so that write is included.
  - `start` with `count == 0` is ignored.
  - `stop` has no effect in LOAD.
- PLAY:
  - `s_rdy` = 0.
  - `start` and `clear` are ignored.
  - Samples mem[0..count-1] are emitted in order. `m_data` holds stable while `m_valid && !m_rdy`.
  - When the last sample (index count-1) is accepted:
    - If `loop_en` is high in that cycle, continue at index 0 with no bubble.
    - Otherwise pulse `done`, then return to LOAD.
  - In both cases `count` and memory contents are preserved, so later writes append and a later `start` replays everything stored.
  - `stop`:
    - State returns to LOAD on the next edge.
    - `m_valid` is 0 from that cycle on.
    - Prefetched data is discarded.
    - No `done` pulse.
    - A handshake occurring in the same cycle as `stop` still counts as delivered.
- `busy` = (state == PLAY).

## Timing
- Reset values (cycle after `rst` sampled high): state LOAD, `count`=0, `m_valid`=0, `m_data`=0, `done`=0, `busy`=0. `s_rdy`=0 while `rst` is high.
- Load accept: 1 sample/cycle. `count` updates on the edge of the handshake.
- RAM read latency is 1 cycle. An output stage of at least 2 entries gives full throughput.
- With `start` sampled at edge N and `m_rdy` held high:
  - `busy`=1 after edge N.
  - `m_valid`=1 with mem[0] after edge N+2.
  - One sample per cycle after that.
- Backpressure: `m_rdy` low for k cycles stalls the output for exactly k cycles. No sample is lost or duplicated.
- `done` is asserted in the cycle after the final handshake, simultaneous with `busy` falling. `s_rdy` returns in that same cycle.
- Wrap when looping: the sample at index count-1 is followed on the next accepting cycle by index 0.
- Full condition: `count == depth` → `s_rdy`=0. Writes resume only after `clear`.

## Structure
- Shared package `rfsoc_pkg`: `num_bits` default, `replay_state_t` enum {LOAD, PLAY}, default `depth`.
- Sub-module `sdp_bram`: simple dual-port RAM, one write port and one registered read port, 1-cycle read latency, inferred as BRAM.

## Test plan
- Load 4 samples (0x1111, 0x2222, 0x3333, 0x4444), `loop_en`=0, `m_rdy`=1, pulse `start` → `m_valid` 2 cycles later; the 4 samples appear in order on consecutive cycles; `done` pulses once; `count` stays 4.
- Same load, `loop_en`=1, random `m_rdy` (50%) for 20 handshakes → output is 0x1111..0x4444 repeated 5 times; no bubble at the wrap when `m_rdy` is high; then `stop` → `m_valid`=0 next cycle, no `done`.
- Write 1024 samples with `s_valid` held high → `s_rdy` drops after the 1024th handshake; the 1025th is not accepted; `count`=1024; full replay matches the written data.
- `clear` coincident with a write handshake → `count`=0; a following `start` is ignored (`busy` stays 0).
- `start` in the same cycle as a write of 0xBEEF with `count`=2 → pass length is 3 and ends with 0xBEEF.
- Assert `rst` mid-PLAY with `m_valid` high → next cycle `m_valid`=0, `count`=0, `busy`=0; a new load and replay works.

Source files
------------

// File: rtl/rfsoc_pkg.sv
// Shared definitions for the RFSoC coefficient datapath blocks.
package rfsoc_pkg;

  localparam int num_bits_default     = 16;
  localparam int replay_depth_default = 1024;

  typedef enum logic {
    LOAD,
    PLAY
  } replay_state_t;

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module sdp_bram #(
  parameter int data_bits = 16,
  parameter int addr_bits = 10
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [data_bits-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [addr_bits-1:0] rd_addr,
  output logic [data_bits-1:0] rd_data
);

  logic [data_bits-1:0] mem [0:(1<<addr_bits)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_replay_buffer.sv
// Coefficient sample buffer: loads words from an AXI-stream slave into BRAM and
// replays the stored sequence on command, optionally looping.
module axis_replay_buffer
  import rfsoc_pkg::*;
#(
  parameter  int num_bits  = num_bits_default,
  parameter  int depth     = replay_depth_default,
  localparam int addr_bits = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [num_bits-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_rdy,
  output logic [num_bits-1:0]  m_data,
  output logic                 m_valid,
  input  logic                 m_rdy,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 loop_en,
  output logic [addr_bits:0]   count,
  output logic                 busy,
  output logic                 done
);

  localparam logic [addr_bits:0] full_count = (addr_bits+1)'(depth);

  replay_state_t state, state_next;

  logic [addr_bits:0]   count_next;
  logic [addr_bits-1:0] rd_ptr, out_idx, last_idx;
  logic                 wr_en, rd_en, pop, last_pop;
  logic                 go, flush, done_next;
  logic                 inflight;
  logic [num_bits-1:0]  ram_rdata;

  // Two-entry output queue behind the RAM register keeps one sample per cycle.
  logic [num_bits-1:0]  skid [2];
  logic [1:0]           fifo_cnt, occupancy;
  logic                 wr_sel, rd_sel;

  sdp_bram #(
    .data_bits (num_bits),
    .addr_bits (addr_bits)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[addr_bits-1:0]),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_rdata)
  );

  assign last_idx  = count[addr_bits-1:0] - addr_bits'(1);
  assign occupancy = fifo_cnt + {1'b0, inflight};
  assign m_valid   = (fifo_cnt != 2'd0);
  assign m_data    = skid[rd_sel];
  assign pop       = m_valid && m_rdy;
  assign last_pop  = pop && (out_idx == last_idx);
  assign busy      = (state == PLAY);

  always_comb begin
    state_next = state;
    count_next = count;
    s_rdy      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    go         = 1'b0;
    flush      = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      LOAD: begin
        s_rdy = !rst && (count != full_count);
        wr_en = s_valid && s_rdy && !clear;
        if (clear) begin
          count_next = '0;
        end else if (wr_en) begin
          count_next = count + (addr_bits+1)'(1);
        end
        // Pass length includes a write landing in the same cycle as start.
        if (start && (count_next != '0)) begin
          state_next = PLAY;
          go         = 1'b1;
        end
      end
      PLAY: begin
        // Reads are prefetched across the wrap; unwanted ones are flushed on exit.
        rd_en = (occupancy <= ({1'b0, pop} + 2'd1));
        if (stop) begin
          state_next = LOAD;
          flush      = 1'b1;
        end else if (last_pop && !loop_en) begin
          state_next = LOAD;
          flush      = 1'b1;
          done_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      count    <= '0;
      done     <= 1'b0;
      rd_ptr   <= '0;
      out_idx  <= '0;
      inflight <= 1'b0;
      fifo_cnt <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      skid     <= '{default: '0};
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;

      if (go) begin
        rd_ptr  <= '0;
        out_idx <= '0;
      end else begin
        if (rd_en) begin
          rd_ptr <= (rd_ptr == last_idx) ? '0 : rd_ptr + addr_bits'(1);
        end
        if (pop) begin
          out_idx <= (out_idx == last_idx) ? '0 : out_idx + addr_bits'(1);
        end
      end

      if (flush) begin
        inflight <= 1'b0;
        fifo_cnt <= '0;
        wr_sel   <= 1'b0;
        rd_sel   <= 1'b0;
      end else begin
        inflight <= rd_en;
        if (inflight) begin
          skid[wr_sel] <= ram_rdata;
          wr_sel       <= !wr_sel;
        end
        if (pop) begin
          rd_sel <= !rd_sel;
        end
        fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_axis_replay_buffer.sv
// Self-checking bench for axis_replay_buffer against a queue-based sample model.
module tb_axis_replay_buffer;

  localparam int nb = 16;
  localparam int dp = 1024;
  localparam int ab = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [nb-1:0] s_data;
  logic          s_valid;
  logic          s_rdy;
  logic [nb-1:0] m_data;
  logic          m_valid;
  logic          m_rdy;
  logic          start, stop, clear, loop_en;
  logic [ab:0]   count;
  logic          busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [nb-1:0] ref_mem [$];

  always #5 clk = ~clk;

  axis_replay_buffer #(
    .num_bits (nb),
    .depth    (dp)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_rdy   (s_rdy),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_rdy   (m_rdy),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .loop_en (loop_en),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(input logic [nb-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    check("s_rdy_load", s_rdy, 1);
    cyc();
    s_valid = 1'b0;
    ref_mem.push_back(d);
    check("count_load", count, ref_mem.size());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    ref_mem.delete();
    check("count_clear", count, 0);
  endtask

  // Start a pass and consume n_hs samples (whole pass when not looping).
  task automatic replay(input int n_hs, input bit loop, input bit rand_rdy,
                        input bit with_write, input logic [nb-1:0] wdata);
    int hs = 0;
    int idx = 0;
    int guard = 0;
    int len;
    bit prev_stall = 1'b0;
    logic [nb-1:0] prev_data = '0;
    loop_en = loop;
    m_rdy   = 1'b0;
    start   = 1'b1;
    if (with_write) begin
      s_valid = 1'b1;
      s_data  = wdata;
      ref_mem.push_back(wdata);
    end
    cyc();
    start   = 1'b0;
    s_valid = 1'b0;
    len = ref_mem.size();
    if (!loop) n_hs = len;
    check("busy_on", busy, 1);
    check("count_start", count, len);
    check("s_rdy_play", s_rdy, 0);
    check("valid_n0", m_valid, 0);
    cyc();
    check("valid_n1", m_valid, 0);
    cyc();
    check("valid_n2", m_valid, 1);
    check("first_data", m_data, ref_mem[0]);
    while (hs < n_hs && guard < 20000) begin
      m_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      check("no_bubble", m_valid, 1);
      check("done_low", done, 0);
      if (prev_stall) check("stall_hold", m_data, prev_data);
      if (m_rdy) begin
        check("data", m_data, ref_mem[idx]);
        hs++;
        idx = (idx + 1) % len;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data  = m_data;
      end
      cyc();
      guard++;
    end
    m_rdy = 1'b0;
    check("handshakes", hs, n_hs);
    if (!loop) begin
      check("done_pulse", done, 1);
      check("busy_off", busy, 0);
      check("s_rdy_back", s_rdy, (len != dp));
      check("valid_off", m_valid, 0);
      check("count_kept", count, len);
      cyc();
      check("done_once", done, 0);
    end
  endtask

  initial begin
    logic [nb-1:0] d;
    bit exp_rdy;
    rst = 1'b1; s_data = '0; s_valid = 1'b0; m_rdy = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; loop_en = 1'b0;
    cyc();
    cyc();
    check("rst_s_rdy", s_rdy, 0);
    check("rst_count", count, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    cyc();
    check("s_rdy_idle", s_rdy, 1);

    // Four-sample single pass, then looping pass with random backpressure and stop.
    load_one(16'h1111);
    load_one(16'h2222);
    load_one(16'h3333);
    load_one(16'h4444);
    replay(4, 1'b0, 1'b0, 1'b0, '0);
    replay(20, 1'b1, 1'b1, 1'b0, '0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_valid", m_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    check("stop_count", count, 4);
    cyc();
    check("stop_done_after", done, 0);

    // stop while loading does nothing
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_load_count", count, 4);
    check("stop_load_busy", busy, 0);

    // Fill to capacity; the 1025th sample must be refused.
    do_clear();
    for (int i = 0; i < dp + 1; i++) begin
      s_valid = 1'b1;
      d = nb'($urandom);
      s_data = d;
      exp_rdy = (ref_mem.size() != dp);
      check("s_rdy_fill", s_rdy, exp_rdy);
      if (exp_rdy) ref_mem.push_back(d);
      cyc();
    end
    s_valid = 1'b0;
    check("count_full", count, dp);
    check("s_rdy_full", s_rdy, 0);
    replay(0, 1'b0, 1'b1, 1'b0, '0);
    check("s_rdy_full_after", s_rdy, 0);

    // clear beats a coincident write; start on empty buffer is ignored.
    do_clear();
    load_one(16'h0A0A);
    load_one(16'h0B0B);
    clear = 1'b1;
    s_valid = 1'b1;
    s_data = 16'h5A5A;
    check("s_rdy_clear_wr", s_rdy, 1);
    cyc();
    clear = 1'b0;
    s_valid = 1'b0;
    ref_mem.delete();
    check("count_clear_wr", count, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_empty_busy", busy, 0);
    cyc();
    check("start_empty_valid", m_valid, 0);

    // start coincident with a write: pass length 3, ending in 0xBEEF.
    load_one(16'h00A1);
    load_one(16'h00A2);
    replay(0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    check("beef_last", ref_mem[2], 16'hBEEF);

    // Reset while replaying.
    replay(3, 1'b1, 1'b0, 1'b0, '0);
    check("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    cyc();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_rdy", s_rdy, 0);
    rst = 1'b0;
    ref_mem.delete();
    cyc();
    for (int i = 0; i < 5; i++) load_one(nb'($urandom));
    replay(0, 1'b0, 1'b1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
